// File: rtl/control_sequencer.sv
// Instruction control sequencer: owns the FETCH/DECODE/EXECUTE/WRITEBACK/OUTPUT FSM and the IR,
// and drives the datapath control word from the current state and the latched instruction.
module control_sequencer #(
    parameter int unsigned CTRL_W          = 16,
    parameter bit          OUTPUT_EN       = 1'b1,
    parameter bit          HALT_ON_ILLEGAL = 1'b1,
    parameter int unsigned CNT_W           = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        instr_in,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              stall,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [2:0]        state_out,
    output logic              illegal,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StDecode    = 3'd1,
        StExecute   = 3'd2,
        StWriteback = 3'd3,
        StOutput    = 3'd4,
        StHalt      = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [1:0]  src, dst;
    logic [3:0]  op;
    logic        legal;
    logic [15:0] exec_word;
    logic [15:0] ctrl_word;

    assign src = ir_q[7:6];
    assign dst = ir_q[5:4];
    assign op  = ir_q[3:0];

    // Execute word and legality of the latched instruction.
    always_comb begin
        legal     = 1'b0;
        exec_word = 16'h0000;
        if (ir_q == 8'h00) begin
            legal     = 1'b1;
            exec_word = 16'h0010;
        end else begin
            case (op)
                4'hA: begin
                    if (dst == 2'd3 && src == 2'd1) begin
                        legal     = 1'b1;
                        exec_word = 16'h381A;
                    end else if (dst == 2'd3 && (src == 2'd0 || src == 2'd2)) begin
                        legal     = 1'b1;
                        exec_word = 16'h384A | {10'b0, src, 4'b0};
                    end else if ((dst == 2'd1 || dst == 2'd2) && src == 2'd0) begin
                        legal     = 1'b1;
                        exec_word = 16'h084A | {2'b0, dst, 12'b0};
                    end
                end
                4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'hB, 4'hC, 4'hD: begin
                    if (dst == 2'd1 && src != 2'd1) begin
                        legal     = 1'b1;
                        exec_word = {10'b0, src, op};
                    end
                end
                4'h3, 4'h4, 4'h8: begin
                    if (src == 2'd0) begin
                        legal     = 1'b1;
                        exec_word = (dst == 2'd1) ? {12'h001, op} : {8'h00, 2'b01, dst, op};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            ir_q      <= 8'h00;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        case (state_q)
            StFetch: begin
                if (instr_valid) begin
                    ir_d    = instr_in;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (!stall) begin
                    if (legal) begin
                        state_d = StExecute;
                    end else begin
                        state_d = HALT_ON_ILLEGAL ? StHalt : StFetch;
                    end
                end
            end
            StExecute: begin
                if (!stall) begin
                    if (ir_q == 8'h00) begin
                        state_d   = StFetch;
                        retired_d = retired_q + CNT_W'(1);
                    end else begin
                        state_d = StWriteback;
                    end
                end
            end
            StWriteback: begin
                if (!stall) begin
                    if (OUTPUT_EN) begin
                        state_d = StOutput;
                    end else begin
                        state_d   = StFetch;
                        retired_d = retired_q + CNT_W'(1);
                    end
                end
            end
            StOutput: begin
                if (!stall) begin
                    state_d   = StFetch;
                    retired_d = retired_q + CNT_W'(1);
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    always_comb begin
        ctrl_word = 16'h0000;
        case (state_q)
            StFetch:     ctrl_word = 16'h0400;
            StDecode:    ctrl_word = (legal && src == 2'd0) ? 16'h0200 : 16'h0000;
            StExecute:   ctrl_word = exec_word;
            StWriteback: ctrl_word = 16'h3880;
            StOutput:    ctrl_word = 16'h0080;
            default:     ctrl_word = 16'h0000;
        endcase
    end

    always_comb begin
        ctrl_out       = '0;
        ctrl_out[15:0] = ctrl_word;
    end

    assign state_out   = state_q;
    assign instr_ready = (state_q == StFetch);
    assign illegal     = (state_q == StDecode) && !legal;
    assign halted      = (state_q == StHalt);
    assign retired     = retired_q;

endmodule
